// File: rtl/accum_out_buffer_pkg.sv
// Shared types, tile geometry and arithmetic helpers for the output-activation accumulator.
// No logic of its own.
// The including modules use these helpers; there is no flow control here.
package accum_out_buffer_pkg;

    localparam int NUM_DST     = 4;
    localparam int DATA_W      = 16;
    localparam int ACC_W       = 24;
    localparam int OUT_ROWS    = 8;
    localparam int OUT_COLS    = 8;
    localparam int OUT_CH      = 4;

    localparam int Y_W         = $clog2(OUT_ROWS);
    localparam int X_W         = $clog2(OUT_COLS);
    localparam int K_W         = $clog2(OUT_CH);
    localparam int LANE_W      = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
    localparam int BANK_DEPTH  = (OUT_ROWS / NUM_DST) * OUT_COLS * OUT_CH;
    localparam int ADDR_W      = $clog2(BANK_DEPTH);
    localparam int TOTAL_WORDS = OUT_ROWS * OUT_COLS * OUT_CH;

    typedef struct packed {
        logic                     valid;
        logic signed [DATA_W-1:0] data;
        logic [X_W-1:0]           x_dir;
        logic [Y_W-1:0]           y_dir;
        logic [K_W-1:0]           k_dir;
    } crossbar_lane_t;

    typedef crossbar_lane_t [NUM_DST-1:0] crossbar_buffer_in_PACKET;

    typedef enum logic [1:0] {
        ACCB_ACCUM,
        ACCB_FLUSH,
        ACCB_DRAIN,
        ACCB_DONE
    } ACCB_STATE;

    function automatic logic [LANE_W-1:0] lane_of(input logic [Y_W-1:0] y);
        int r;
        r = int'(y) % NUM_DST;
        return r[LANE_W-1:0];
    endfunction

    function automatic logic coord_in_range(input logic [Y_W-1:0] y,
                                            input logic [X_W-1:0] x,
                                            input logic [K_W-1:0] k);
        return (int'(y) < OUT_ROWS) && (int'(x) < OUT_COLS) && (int'(k) < OUT_CH);
    endfunction

    // Rows are interleaved across lanes, so each bank only holds every NUM_DST-th row.
    function automatic logic [ADDR_W-1:0] bank_addr(input logic [Y_W-1:0] y,
                                                    input logic [X_W-1:0] x,
                                                    input logic [K_W-1:0] k);
        int a;
        a = (int'(y) / NUM_DST) * OUT_COLS * OUT_CH + int'(x) * OUT_CH + int'(k);
        return a[ADDR_W-1:0];
    endfunction

    function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0]  acc,
                                                        input logic signed [DATA_W-1:0] d);
        logic signed [ACC_W:0] s;
        s = {acc[ACC_W-1], acc} + {{(ACC_W+1-DATA_W){d[DATA_W-1]}}, d};
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

endpackage

// File: rtl/accum_out_buffer_lane.sv
// One accumulator bank with a two-stage read-modify-write pipeline and a drain read/clear port.
// Latency: the bank is updated two edges after an input is presented; the drain read is combinational.
// Backpressure: none; every valid input is absorbed, and same-address hits are forwarded.
module accum_lane
    import accum_out_buffer_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     acc_valid,
    input  logic [ADDR_W-1:0]        acc_addr,
    input  logic signed [DATA_W-1:0] acc_data,
    input  logic                     drain_clear,
    input  logic [ADDR_W-1:0]        drain_addr,
    output logic signed [ACC_W-1:0]  drain_data
);

    logic signed [ACC_W-1:0]  bank [BANK_DEPTH];

    logic                     s1_valid;
    logic [ADDR_W-1:0]        s1_addr;
    logic signed [DATA_W-1:0] s1_data;
    logic signed [ACC_W-1:0]  s1_rd_q;

    logic signed [ACC_W-1:0]  s2_sum;
    logic                     s2_hit;

    assign s2_sum     = sat_add(s1_rd_q, s1_data);
    // The write of s2_sum lands on the same edge as the next read, so that read must take the sum.
    assign s2_hit     = s1_valid && (s1_addr == acc_addr);
    assign drain_data = bank[drain_addr];

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_data  <= '0;
            s1_rd_q  <= '0;
        end else begin
            s1_valid <= acc_valid;
            s1_addr  <= acc_addr;
            s1_data  <= acc_data;
            s1_rd_q  <= s2_hit ? s2_sum : bank[acc_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BANK_DEPTH; i++)
                bank[i] <= '0;
        end else begin
            if (s1_valid)
                bank[s1_addr] <= s2_sum;
            if (drain_clear)
                bank[drain_addr] <= '0;
        end
    end

endmodule

// File: rtl/accum_out_buffer.sv
// Output-activation accumulator: NUM_DST row-interleaved lanes plus a drain FSM that streams the tile.
// Latency: 2-cycle flush after drain_start, then one word per accepted handshake in (y, x, k) order.
// Backpressure: out_valid/out_ready on the drain side; buf_busy tells the PE to stall; input is never stalled.
module accum_out_buffer
    import accum_out_buffer_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  crossbar_buffer_in_PACKET buffer_packet,
    input  logic                     drain_start,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [ACC_W-1:0]  out_data,
    output logic [Y_W-1:0]           out_y,
    output logic [X_W-1:0]           out_x,
    output logic [K_W-1:0]           out_k,
    output logic                     drain_done,
    output logic                     buf_busy,
    output logic                     err_drop
);

    ACCB_STATE               state;
    ACCB_STATE               state_nxt;
    logic                    flush_cnt;

    logic [Y_W-1:0]          cnt_y;
    logic [X_W-1:0]          cnt_x;
    logic [K_W-1:0]          cnt_k;
    logic                    loaded_all;
    logic                    last_word;
    logic                    load;
    logic                    accept_last;

    logic [LANE_W-1:0]       drain_lane;
    logic [ADDR_W-1:0]       drain_addr;
    logic signed [ACC_W-1:0] lane_rd [NUM_DST];
    logic [NUM_DST-1:0]      lane_err;

    assign drain_lane = lane_of(cnt_y);
    assign drain_addr = bank_addr(cnt_y, cnt_x, cnt_k);

    for (genvar l = 0; l < NUM_DST; l++) begin : g_lane
        crossbar_lane_t    pkt;
        logic              route_ok;
        logic              acc_valid;
        logic              drain_clear;
        logic [ADDR_W-1:0] acc_addr;

        assign pkt         = buffer_packet[l];
        assign route_ok    = (lane_of(pkt.y_dir) == LANE_W'(l))
                             && coord_in_range(pkt.y_dir, pkt.x_dir, pkt.k_dir);
        assign acc_valid   = pkt.valid && route_ok && (state == ACCB_ACCUM);
        assign lane_err[l] = pkt.valid && !(route_ok && (state == ACCB_ACCUM));
        assign acc_addr    = bank_addr(pkt.y_dir, pkt.x_dir, pkt.k_dir);
        assign drain_clear = load && (drain_lane == LANE_W'(l));

        accum_lane u_lane (
            .clock       (clock),
            .reset       (reset),
            .acc_valid   (acc_valid),
            .acc_addr    (acc_addr),
            .acc_data    (pkt.data),
            .drain_clear (drain_clear),
            .drain_addr  (drain_addr),
            .drain_data  (lane_rd[l])
        );

        // A row landing on the wrong lane means the crossbar routed it incorrectly.
        a_lane_route: assert property (@(posedge clock) disable iff (reset)
            pkt.valid |-> (lane_of(pkt.y_dir) == LANE_W'(l)));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ACCB_ACCUM;
            flush_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            flush_cnt <= (state == ACCB_FLUSH) ? ~flush_cnt : 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCB_ACCUM: if (drain_start) state_nxt = ACCB_FLUSH;
            ACCB_FLUSH: if (flush_cnt)   state_nxt = ACCB_DRAIN;
            ACCB_DRAIN: if (accept_last) state_nxt = ACCB_DONE;
            ACCB_DONE:                   state_nxt = ACCB_ACCUM;
            default:                     state_nxt = ACCB_ACCUM;
        endcase
    end

    assign buf_busy    = (state != ACCB_ACCUM);
    assign drain_done  = (state == ACCB_DONE);

    assign last_word   = (cnt_y == Y_W'(OUT_ROWS - 1)) && (cnt_x == X_W'(OUT_COLS - 1))
                         && (cnt_k == K_W'(OUT_CH - 1));
    assign load        = (state == ACCB_DRAIN) && !loaded_all && (!out_valid || out_ready);
    assign accept_last = (state == ACCB_DRAIN) && loaded_all && out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_y      <= '0;
            cnt_x      <= '0;
            cnt_k      <= '0;
            loaded_all <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_y      <= '0;
            out_x      <= '0;
            out_k      <= '0;
        end else if (state != ACCB_DRAIN) begin
            cnt_y      <= '0;
            cnt_x      <= '0;
            cnt_k      <= '0;
            loaded_all <= 1'b0;
            out_valid  <= 1'b0;
        end else if (load) begin
            out_valid  <= 1'b1;
            out_data   <= lane_rd[drain_lane];
            out_y      <= cnt_y;
            out_x      <= cnt_x;
            out_k      <= cnt_k;
            loaded_all <= last_word;
            if (cnt_k == K_W'(OUT_CH - 1)) begin
                cnt_k <= '0;
                if (cnt_x == X_W'(OUT_COLS - 1)) begin
                    cnt_x <= '0;
                    cnt_y <= cnt_y + 1'b1;
                end else begin
                    cnt_x <= cnt_x + 1'b1;
                end
            end else begin
                cnt_k <= cnt_k + 1'b1;
            end
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            err_drop <= 1'b0;
        else if (|lane_err)
            err_drop <= 1'b1;
    end

endmodule

// File: tb/tb_accum_out_buffer.sv
// Directed bench for accum_out_buffer: writes, forwarding, saturation, stalled drain, drop and reset-abort.
module tb_accum_out_buffer;
    import accum_out_buffer_pkg::*;

    logic                     clock = 1'b0;
    logic                     reset;
    crossbar_buffer_in_PACKET buffer_packet;
    logic                     drain_start;
    logic                     out_ready;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_data;
    logic [Y_W-1:0]           out_y;
    logic [X_W-1:0]           out_x;
    logic [K_W-1:0]           out_k;
    logic                     drain_done;
    logic                     buf_busy;
    logic                     err_drop;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_mem [OUT_ROWS][OUT_COLS][OUT_CH];
    int got     [OUT_ROWS][OUT_COLS][OUT_CH];

    always #5 clock = ~clock;

    accum_out_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .buffer_packet (buffer_packet),
        .drain_start   (drain_start),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_y         (out_y),
        .out_x         (out_x),
        .out_k         (out_k),
        .drain_done    (drain_done),
        .buf_busy      (buf_busy),
        .err_drop      (err_drop)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic int sat24(input int v);
        if (v > 8388607)
            return 8388607;
        if (v < -8388608)
            return -8388608;
        return v;
    endfunction

    task automatic clear_model();
        for (int y = 0; y < OUT_ROWS; y++)
            for (int x = 0; x < OUT_COLS; x++)
                for (int k = 0; k < OUT_CH; k++)
                    exp_mem[y][x][k] = 0;
    endtask

    task automatic stage(input int y, input int x, input int k, input int d);
        int l;
        l = y % NUM_DST;
        buffer_packet[l].valid = 1'b1;
        buffer_packet[l].data  = DATA_W'(d);
        buffer_packet[l].y_dir = Y_W'(y);
        buffer_packet[l].x_dir = X_W'(x);
        buffer_packet[l].k_dir = K_W'(k);
        exp_mem[y][x][k] = sat24(exp_mem[y][x][k] + d);
    endtask

    task automatic step();
        @(negedge clock);
        buffer_packet = '0;
    endtask

    // Streams the tile, checking order, value and stall stability; optionally injects a
    // stray input after inject_at words, or pulls reset after abort_at words.
    task automatic drain(input bit toggle, input int inject_at, input int abort_at);
        int idx = 0;
        int cyc = 0;
        int limit;
        int coord;
        int h_data = 0;
        int h_coord = 0;
        bit stalled = 1'b0;
        bit injected = 1'b0;
        limit = (abort_at > 0) ? abort_at : TOTAL_WORDS;
        drain_start = 1'b1;
        @(negedge clock);
        drain_start = 1'b0;
        #1 chk("busy_on", int'(buf_busy), 1);
        while (idx < limit && cyc < 4000) begin
            out_ready = toggle ? cyc[0] : 1'b1;
            #1;
            coord = int'(out_y) * OUT_COLS * OUT_CH + int'(out_x) * OUT_CH + int'(out_k);
            if (stalled) begin
                chk("stall_vld", int'(out_valid), 1);
                chk("stall_data", int'(out_data), h_data);
                chk("stall_coord", coord, h_coord);
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                chk("order", coord, idx);
                chk("data", int'(out_data), exp_mem[out_y][out_x][out_k]);
                got[out_y][out_x][out_k] = int'(out_data);
                idx++;
            end else if (out_valid) begin
                stalled = 1'b1;
                h_data  = int'(out_data);
                h_coord = coord;
            end
            if (idx == inject_at && !injected) begin
                buffer_packet[2].valid = 1'b1;
                buffer_packet[2].data  = DATA_W'(55);
                buffer_packet[2].y_dir = Y_W'(6);
                buffer_packet[2].x_dir = X_W'(1);
                buffer_packet[2].k_dir = K_W'(1);
                injected = 1'b1;
            end
            @(negedge clock);
            buffer_packet = '0;
            cyc++;
        end
        if (abort_at > 0) begin
            chk("abort_words", idx, abort_at);
            chk("abort_pre_vld", int'(out_valid), 1);
            reset     = 1'b1;
            out_ready = 1'b0;
            @(negedge clock);
            reset = 1'b0;
            #1;
            chk("abort_vld", int'(out_valid), 0);
            chk("abort_busy", int'(buf_busy), 0);
            chk("abort_err", int'(err_drop), 0);
            chk("abort_done", int'(drain_done), 0);
            repeat (3) begin
                @(negedge clock);
                #1 chk("abort_no_done", int'(drain_done), 0);
            end
        end else begin
            chk("words", idx, TOTAL_WORDS);
            #1;
            chk("done_pulse", int'(drain_done), 1);
            chk("done_vld_low", int'(out_valid), 0);
            @(negedge clock);
            #1;
            chk("done_clear", int'(drain_done), 0);
            chk("idle", int'(buf_busy), 0);
        end
        clear_model();
        out_ready = 1'b0;
    endtask

    initial begin
        buffer_packet = '0;
        drain_start   = 1'b0;
        out_ready     = 1'b0;
        reset         = 1'b1;
        clear_model();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_drain_done", int'(drain_done), 0);
        chk("rst_buf_busy", int'(buf_busy), 0);
        chk("rst_err_drop", int'(err_drop), 0);

        // single write
        stage(5, 2, 1, 7);
        step();
        drain(1'b0, -1, -1);
        chk("t1_word", got[5][2][1], 7);
        chk("t1_other", got[5][2][0], 0);

        // back-to-back hits on one address
        for (int i = 1; i <= 4; i++) begin
            stage(3, 4, 2, i);
            step();
        end
        drain(1'b0, -1, -1);
        chk("t2_fwd", got[3][4][2], 10);

        // all lanes busy with random data
        for (int c = 0; c < 64; c++) begin
            for (int l = 0; l < NUM_DST; l++)
                stage(l + NUM_DST * int'($urandom_range(0, 1)), int'($urandom_range(0, OUT_COLS - 1)),
                      int'($urandom_range(0, OUT_CH - 1)), int'($urandom_range(0, 65535)) - 32768);
            step();
        end
        drain(1'b0, -1, -1);

        // saturation at both rails, drained with a stalling consumer
        repeat (256) begin
            stage(0, 0, 0, 32767);
            stage(1, 0, 0, -32768);
            step();
        end
        stage(0, 0, 0, 255);
        step();
        stage(0, 0, 0, 5);
        stage(1, 0, 0, -1);
        step();
        drain(1'b1, -1, -1);
        chk("t4_pos_sat", got[0][0][0], 8388607);
        chk("t4_neg_sat", got[1][0][0], -8388608);
        drain(1'b0, -1, -1);
        chk("t5_zero", got[0][0][0], 0);
        chk("t5_no_err", int'(err_drop), 0);

        // stray input during drain is dropped
        stage(7, 7, 3, 100);
        step();
        drain(1'b0, 10, -1);
        chk("t6_err", int'(err_drop), 1);
        chk("t6_unchanged", got[6][1][1], 0);
        chk("t6_word", got[7][7][3], 100);

        // reset part-way through a drain
        stage(2, 3, 1, -40);
        step();
        drain(1'b0, -1, 37);
        drain(1'b0, -1, -1);
        chk("t6_rst_zero", got[2][3][1], 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
